// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl
//   Decode stage with register-dependency and branch hazard control.
//   Decodes the fetched instruction word, keeps a 16-entry busy scoreboard
//   for destination registers in flight, stalls fetch on a read-after-write
//   or write-after-write hazard, and holds fetch while a branch is resolved.
//
// Configuration:
//   DECODE_SB_BYPASS_EN - when defined, a writeback clear in the current
//                         cycle is visible to the hazard check, so a
//                         dependent instruction issues in the writeback
//                         cycle instead of one cycle later.
//
// Ports:
//   I_CLOCK             clock, all state on rising edge
//   I_RESET             synchronous active-high reset
//   I_PC, I_IR          fetched PC / instruction word
//   I_FE_Valid          fetched instruction is real
//   I_WB_Valid          writeback retires I_WB_DestReg this cycle
//   I_WB_DestReg        register retired by writeback
//   I_BranchAddrSelect  branch target resolved
//   O_BranchStallSignal combinational branch stall to fetch
//   O_DepStallSignal    combinational dependency stall to fetch
//   O_PC..O_Imm         registered decoded fields
//   O_DE_Valid          decoded fields valid this cycle
//   O_StallCount        saturating count of stall cycles
module decode_hazard_ctrl (
    input  logic        I_CLOCK,
    input  logic        I_RESET,
    input  logic [15:0] I_PC,
    input  logic [31:0] I_IR,
    input  logic        I_FE_Valid,
    input  logic        I_WB_Valid,
    input  logic [3:0]  I_WB_DestReg,
    input  logic        I_BranchAddrSelect,
    output logic        O_BranchStallSignal,
    output logic        O_DepStallSignal,
    output logic [15:0] O_PC,
    output logic [7:0]  O_Opcode,
    output logic [3:0]  O_DestReg,
    output logic [3:0]  O_Src1,
    output logic [3:0]  O_Src2,
    output logic [15:0] O_Imm,
    output logic        O_DE_Valid,
    output logic [15:0] O_StallCount
);

    typedef enum logic {
        IDLE,
        BR_WAIT
    } state_t;

    state_t      state;
    logic [15:0] busy;

    logic [7:0]  opcode;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [15:0] imm;

    assign opcode = I_IR[31:24];
    assign dest   = I_IR[23:20];
    assign src1   = I_IR[19:16];
    assign src2   = I_IR[11:8];
    assign imm    = I_IR[15:0];

    logic is_nop;
    logic is_branch;
    logic is_writer;

    assign is_nop    = (opcode == 8'hFF);
    assign is_branch = (opcode[7:3] == 5'b00100);   // 8'h20..8'h27
    assign is_writer = !is_nop && !is_branch;

    logic [15:0] wb_clear_mask;
    logic [15:0] set_mask;
    logic [15:0] busy_view;

    always_comb begin
        wb_clear_mask = '0;
        if (I_WB_Valid)
            wb_clear_mask[I_WB_DestReg] = 1'b1;
    end

`ifdef DECODE_SB_BYPASS_EN
    assign busy_view = busy & ~wb_clear_mask;
`else
    assign busy_view = busy;
`endif

    logic src_hazard;
    logic dest_hazard;
    logic dep_stall;
    logic br_stall;
    logic issue;

    always_comb begin
        src_hazard  = !is_nop && (busy_view[src1] || busy_view[src2]);
        dest_hazard = is_writer && busy_view[dest];
        dep_stall   = I_FE_Valid && (state == IDLE) && (src_hazard || dest_hazard);
        issue       = I_FE_Valid && (state == IDLE) && !dep_stall;
        br_stall    = (state == BR_WAIT) || (I_FE_Valid && is_branch && !dep_stall);
        set_mask    = '0;
        if (issue && is_writer)
            set_mask[dest] = 1'b1;
    end

    assign O_DepStallSignal    = dep_stall;
    assign O_BranchStallSignal = br_stall;

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            state        <= IDLE;
            busy         <= '0;
            O_StallCount <= '0;
            O_DE_Valid   <= 1'b0;
            O_PC         <= '0;
            O_Opcode     <= 8'hFF;
            O_DestReg    <= '0;
            O_Src1       <= '0;
            O_Src2       <= '0;
            O_Imm        <= '0;
        end else begin
            // Clear is applied before set so a same-edge set/clear of one
            // register leaves it busy.
            busy       <= (busy & ~wb_clear_mask) | set_mask;
            O_DE_Valid <= issue;
            if (issue) begin
                O_PC      <= I_PC;
                O_Opcode  <= opcode;
                O_DestReg <= dest;
                O_Src1    <= src1;
                O_Src2    <= src2;
                O_Imm     <= imm;
            end

            case (state)
                IDLE: begin
                    if (issue && is_branch)
                        state <= BR_WAIT;
                end
                BR_WAIT: begin
                    if (I_BranchAddrSelect)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if ((dep_stall || br_stall) && (O_StallCount != 16'hFFFF))
                O_StallCount <= O_StallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb_decode_hazard_ctrl
//   Directed scenarios with literal expectations followed by randomized
//   traffic; a behavioural model checks every output on every cycle.
module tb_decode_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic [31:0] ir;
    logic        fe;
    logic        wbv;
    logic [3:0]  wbd;
    logic        bas;
    logic        br_stall;
    logic        dep_stall;
    logic [15:0] o_pc;
    logic [7:0]  o_op;
    logic [3:0]  o_dest;
    logic [3:0]  o_s1;
    logic [3:0]  o_s2;
    logic [15:0] o_imm;
    logic        o_dev;
    logic [15:0] o_cnt;

    int errors = 0;
    int checks = 0;

    decode_hazard_ctrl dut (
        .I_CLOCK(clk),
        .I_RESET(rst),
        .I_PC(pc),
        .I_IR(ir),
        .I_FE_Valid(fe),
        .I_WB_Valid(wbv),
        .I_WB_DestReg(wbd),
        .I_BranchAddrSelect(bas),
        .O_BranchStallSignal(br_stall),
        .O_DepStallSignal(dep_stall),
        .O_PC(o_pc),
        .O_Opcode(o_op),
        .O_DestReg(o_dest),
        .O_Src1(o_s1),
        .O_Src2(o_s2),
        .O_Imm(o_imm),
        .O_DE_Valid(o_dev),
        .O_StallCount(o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
`ifdef DECODE_SB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    bit          m_known = 0;
    bit          m_busy[16];
    bit          m_wait;
    bit          m_dev;
    logic [15:0] m_pc;
    logic [7:0]  m_op;
    logic [3:0]  m_dest, m_s1, m_s2;
    logic [15:0] m_imm;
    int          m_cnt;

    function automatic bit reg_busy(input int r);
        if (BYPASS && wbv && (int'(wbd) == r))
            return 1'b0;
        return m_busy[r];
    endfunction

    always begin
        int  op, d, s1, s2;
        bit  nop, br, reads, writes, e_dep, e_br, e_issue;
        @(negedge clk);
        op = int'(ir[31:24]);
        d  = int'(ir[23:20]);
        s1 = int'(ir[19:16]);
        s2 = int'(ir[11:8]);
        nop    = (op == 255);
        br     = (op >= 32) && (op <= 39);
        reads  = !nop;
        writes = !nop && !br;
        e_dep  = 1'b0;
        e_br   = 1'b0;
        if (fe && !m_wait) begin
            if (reads && (reg_busy(s1) || reg_busy(s2))) e_dep = 1'b1;
            if (writes && reg_busy(d)) e_dep = 1'b1;
        end
        e_br    = m_wait || (fe && br && !e_dep);
        e_issue = fe && !m_wait && !e_dep;

        if (m_known) begin
            check("m_dep_stall", {31'd0, dep_stall}, {31'd0, e_dep});
            check("m_br_stall", {31'd0, br_stall}, {31'd0, e_br});
            check("m_de_valid", {31'd0, o_dev}, {31'd0, m_dev});
            check("m_pc", {16'd0, o_pc}, {16'd0, m_pc});
            check("m_opcode", {24'd0, o_op}, {24'd0, m_op});
            check("m_fields", {20'd0, o_dest, o_s1, o_s2}, {20'd0, m_dest, m_s1, m_s2});
            check("m_imm", {16'd0, o_imm}, {16'd0, m_imm});
            check("m_stall_count", {16'd0, o_cnt}, m_cnt);
        end

        // advance the model across the coming rising edge
        if (rst) begin
            m_known = 1;
            foreach (m_busy[i]) m_busy[i] = 0;
            m_wait = 0; m_dev = 0; m_pc = '0; m_op = 8'hFF;
            m_dest = '0; m_s1 = '0; m_s2 = '0; m_imm = '0; m_cnt = 0;
        end else if (m_known) begin
            if (e_dep || e_br) m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            if (wbv) m_busy[int'(wbd)] = 0;
            if (e_issue && writes) m_busy[d] = 1;
            if (m_wait) begin
                if (bas) m_wait = 0;
            end else if (e_issue && br) begin
                m_wait = 1;
            end
            m_dev = e_issue;
            if (e_issue) begin
                m_pc = pc; m_op = ir[31:24]; m_dest = ir[23:20];
                m_s1 = ir[19:16]; m_s2 = ir[11:8]; m_imm = ir[15:0];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit f, input logic [31:0] i, input logic [15:0] p,
                          input bit wv, input logic [3:0] wd, input bit b, input bit r);
        fe = f; ir = i; pc = p; wbv = wv; wbd = wd; bas = b; rst = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        set_in(0, 32'h0, 16'h0, 0, 4'h0, 0, 1);
        tick();

        // reset state and first writer issue
        set_in(0, 32'hFF000000, 16'h0, 0, 4'h0, 0, 0);
        mid();
        check("rst_de_valid", {31'd0, o_dev}, 32'd0);
        check("rst_opcode", {24'd0, o_op}, 32'hFF);
        check("rst_count", {16'd0, o_cnt}, 32'd0);
        check("rst_pc", {16'd0, o_pc}, 32'd0);
        tick();
        set_in(1, 32'h01320000, 16'h0100, 0, 4'h0, 0, 0);
        mid();
        check("w3_no_dep", {31'd0, dep_stall}, 32'd0);
        check("w3_no_br", {31'd0, br_stall}, 32'd0);
        tick();

        // dependent reader of r3
        set_in(1, 32'h05430000, 16'h0104, 0, 4'h0, 0, 0);
        mid();
        check("w3_de_valid", {31'd0, o_dev}, 32'd1);
        check("w3_dest", {28'd0, o_dest}, 32'd3);
        check("w3_opcode", {24'd0, o_op}, 32'h01);
        check("w3_pc", {16'd0, o_pc}, 32'h0100);
        check("r3_busy_dep", {31'd0, dep_stall}, 32'd1);
        tick();
        mid();
        check("dep_hold_de_valid", {31'd0, o_dev}, 32'd0);
        check("dep_hold_dest", {28'd0, o_dest}, 32'd3);
        check("dep_still", {31'd0, dep_stall}, 32'd1);
        tick();
        set_in(1, 32'h05430000, 16'h0104, 1, 4'h3, 0, 0);
        mid();
`ifdef DECODE_SB_BYPASS_EN
        check("wb_cycle_dep", {31'd0, dep_stall}, 32'd0);
        tick();
`else
        check("wb_cycle_dep", {31'd0, dep_stall}, 32'd1);
        tick();
        set_in(1, 32'h05430000, 16'h0104, 0, 4'h0, 0, 0);
        mid();
        check("wb_plus1_dep", {31'd0, dep_stall}, 32'd0);
        check("wb_plus1_de_valid", {31'd0, o_dev}, 32'd0);
        tick();
`endif
        set_in(0, 32'hFF000000, 16'h0, 0, 4'h0, 0, 0);
        mid();
        check("dep_issue_de_valid", {31'd0, o_dev}, 32'd1);
        check("dep_issue_dest", {28'd0, o_dest}, 32'd4);
        tick();

        // same-edge set and clear of r5
        set_in(1, 32'h01500000, 16'h0108, 1, 4'h5, 0, 0);
        mid();
        check("r5_set_no_dep", {31'd0, dep_stall}, 32'd0);
        tick();
        set_in(1, 32'h06650000, 16'h010C, 0, 4'h0, 0, 0);
        mid();
        check("r5_set_wins", {31'd0, dep_stall}, 32'd1);
        tick();
        set_in(0, 32'h0, 16'h0, 0, 4'h0, 0, 1);
        tick();

        // branch hold and discard
        set_in(1, 32'h20120000, 16'h0200, 0, 4'h0, 0, 0);
        mid();
        check("br_issue_stall", {31'd0, br_stall}, 32'd1);
        check("br_issue_no_dep", {31'd0, dep_stall}, 32'd0);
        tick();
        set_in(1, 32'h01700000, 16'h0204, 0, 4'h0, 0, 0);
        mid();
        check("br_de_valid", {31'd0, o_dev}, 32'd1);
        check("br_opcode", {24'd0, o_op}, 32'h20);
        check("br_wait1", {31'd0, br_stall}, 32'd1);
        tick();
        mid();
        check("br_discard", {31'd0, o_dev}, 32'd0);
        check("br_wait2", {31'd0, br_stall}, 32'd1);
        tick();
        set_in(1, 32'h01700000, 16'h0204, 0, 4'h0, 1, 0);
        mid();
        check("br_wait3", {31'd0, br_stall}, 32'd1);
        tick();
        set_in(0, 32'hFF000000, 16'h0, 0, 4'h0, 0, 0);
        mid();
        check("br_released", {31'd0, br_stall}, 32'd0);
        check("br_count", {16'd0, o_cnt}, 32'd4);
        check("br_discard_pc", {16'd0, o_pc}, 32'h0200);
        tick();
        set_in(1, 32'h06070000, 16'h0210, 0, 4'h0, 0, 0);
        mid();
        check("discard_no_busy", {31'd0, dep_stall}, 32'd0);
        tick();

        // reset during BR_WAIT with r2 busy
        set_in(0, 32'h0, 16'h0, 0, 4'h0, 0, 1);
        tick();
        set_in(1, 32'h01200000, 16'h0300, 0, 4'h0, 0, 0);
        tick();
        set_in(1, 32'h21000000, 16'h0304, 0, 4'h0, 0, 0);
        tick();
        set_in(0, 32'hFF000000, 16'h0, 0, 4'h0, 0, 0);
        mid();
        check("brw_in_wait", {31'd0, br_stall}, 32'd1);
        tick();
        set_in(0, 32'h0, 16'h0, 0, 4'h0, 0, 1);
        tick();
        set_in(0, 32'hFF000000, 16'h0, 0, 4'h0, 0, 0);
        mid();
        check("brw_rst_idle", {31'd0, br_stall}, 32'd0);
        check("brw_rst_opcode", {24'd0, o_op}, 32'hFF);
        check("brw_rst_count", {16'd0, o_cnt}, 32'd0);
        check("brw_rst_dev", {31'd0, o_dev}, 32'd0);
        tick();
        set_in(1, 32'h06020000, 16'h0308, 0, 4'h0, 0, 0);
        mid();
        check("brw_rst_r2_free", {31'd0, dep_stall}, 32'd0);
        tick();

        // long stall saturation
        set_in(0, 32'h0, 16'h0, 0, 4'h0, 0, 1);
        tick();
        set_in(1, 32'h20000000, 16'h0400, 0, 4'h0, 0, 0);
        tick();
        set_in(0, 32'hFF000000, 16'h0, 0, 4'h0, 0, 0);
        repeat (70000) tick();
        mid();
        check("sat_count", {16'd0, o_cnt}, 32'hFFFF);
        check("sat_still_wait", {31'd0, br_stall}, 32'd1);
        tick();
        set_in(0, 32'h0, 16'h0, 0, 4'h0, 0, 1);
        tick();

        // randomized traffic
        repeat (4000) begin
            logic [7:0]  op;
            logic [31:0] w;
            case ($urandom_range(0, 3))
                0:       op = 8'hFF;
                1:       op = 8'h20 + 8'($urandom_range(0, 7));
                default: op = 8'($urandom_range(0, 31));
            endcase
            w = {op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
            set_in($urandom_range(0, 3) != 0, w, 16'($urandom_range(0, 65535)),
                   $urandom_range(0, 2) == 0, 4'($urandom_range(0, 7)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
            tick();
        end
        set_in(0, 32'hFF000000, 16'h0, 0, 4'h0, 0, 0);
        mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
